// File: rtl/multi_counter_strobe_pkg.sv
// Shared types and helpers for the multi_counter_strobe strobe bank.
package multi_counter_strobe_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    localparam int unsigned CNT_RESET_VAL = 1;
    localparam int unsigned MAX_WIDTH     = 64;

    // A period of 0 behaves like 1 so a channel can never stall forever.
    function automatic logic [MAX_WIDTH-1:0] eff_period(input logic [MAX_WIDTH-1:0] p);
        return (p == '0) ? MAX_WIDTH'(1) : p;
    endfunction

endpackage

// File: rtl/strobe_channel.sv
// One counter channel: counts enabled ticks and emits a 1-cycle strobe at each period end.
module strobe_channel
    import multi_counter_strobe_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             enable,
    input  logic             arm,
    input  logic             disarm,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    output logic             strobe,
    output logic             busy
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] eff;
    mode_e            mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             strobe_q, strobe_d;
    logic             count_en;
    logic             terminal;

    assign eff      = WIDTH'(eff_period(MAX_WIDTH'(per_q)));
    assign count_en = busy_q & enable & tick;
    assign terminal = count_en & (cnt_q == eff);

    // Priority: disarm over arm over terminal; the terminal strobe itself is never suppressed.
    always_comb begin
        cnt_d    = cnt_q;
        per_d    = per_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        strobe_d = terminal;
        if (disarm) begin
            busy_d = 1'b0;
            cnt_d  = WIDTH'(CNT_RESET_VAL);
        end else if (arm) begin
            busy_d = 1'b1;
            cnt_d  = WIDTH'(CNT_RESET_VAL);
            per_d  = period;
            mode_d = mode_e'(oneshot);
        end else if (terminal) begin
            cnt_d = WIDTH'(CNT_RESET_VAL);
            per_d = period;
            if (mode_q == MODE_ONESHOT) begin
                busy_d = 1'b0;
            end
        end else if (count_en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= WIDTH'(CNT_RESET_VAL);
            per_q    <= WIDTH'(CNT_RESET_VAL);
            mode_q   <= MODE_PERIODIC;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;
    assign busy   = busy_q;

endmodule

// File: rtl/multi_counter_strobe.sv
// Bank of independent strobe counters sharing one clock; optional shared prescaler
// enabled by defining MULTI_STROBE_PRESCALE_EN.
module multi_counter_strobe
    import multi_counter_strobe_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PRE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       arm,
    input  logic [CHANNELS-1:0]       disarm,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS*WIDTH-1:0] period,
`ifdef MULTI_STROBE_PRESCALE_EN
    input  logic [PRE_WIDTH-1:0]      prescale,
`endif
    output logic [CHANNELS-1:0]       strobe,
    output logic [CHANNELS-1:0]       busy
);

    if (CHANNELS < 1 || WIDTH < 2 || WIDTH > MAX_WIDTH || PRE_WIDTH < 1) begin : g_bad_params
        $error("multi_counter_strobe: illegal parameter value");
    end

    logic tick;

`ifdef MULTI_STROBE_PRESCALE_EN
    logic [PRE_WIDTH-1:0] pre_q;
    logic                 pre_wrap;

    // Wrapping at all-ones covers a prescale lowered below the current count.
    assign pre_wrap = (pre_q == prescale) || (pre_q == '1);
    assign tick     = pre_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (pre_wrap) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_WIDTH'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        strobe_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .enable (enable[i]),
            .arm    (arm[i]),
            .disarm (disarm[i]),
            .oneshot(oneshot[i]),
            .period (period[i*WIDTH +: WIDTH]),
            .strobe (strobe[i]),
            .busy   (busy[i])
        );
    end

endmodule
